// File: rtl/mem_copy_if.sv
// rtl/mem_copy_if.sv - SDRAM bridge bus between the copy engine and the wishbone bridge
interface mem_copy_if;
   logic        mem_copy;
   logic        mem_copy_virt;
   logic [24:0] mem_copy_addr;
   logic [15:0] mem_copy_data_i;
   logic [15:0] mem_copy_data_o;
   logic        mem_copy_rd;
   logic        mem_copy_we;

   modport master (
      output mem_copy, mem_copy_virt, mem_copy_addr, mem_copy_data_i,
             mem_copy_rd, mem_copy_we,
      input  mem_copy_data_o
   );

   modport slave (
      input  mem_copy, mem_copy_virt, mem_copy_addr, mem_copy_data_i,
             mem_copy_rd, mem_copy_we,
      output mem_copy_data_o
   );
endinterface

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word copy/fill engine driving the SDRAM bridge with timed strobes
module mem_copy_dma #(
   parameter int STROBE = 4,
   parameter int WAIT   = 24
) (
   input  logic         clk_sys,
   input  logic         init_n,
   input  logic         start,
   input  logic         fill,
   input  logic         virt,
   input  logic [24:0]  src_addr,
   input  logic [24:0]  dst_addr,
   input  logic [15:0]  len,
   input  logic [15:0]  fill_data,
   input  logic         abort,
   mem_copy_if.master   bus,
   output logic         busy,
   output logic         done,
   output logic         aborted
);

   // NEXT never occupies a cycle: its work happens on the last WWAIT cycle.
   typedef enum logic [2:0] {
      IDLE, SETUP, READ, RWAIT, WRITE, WWAIT, NEXT, DONE
   } state_t;

   localparam logic [15:0] S_LAST = 16'(STROBE - 1);
   localparam logic [15:0] W_LAST = 16'(WAIT - 1);

   state_t      state, next_state;
   logic [15:0] timer;
   logic [15:0] cnt;
   logic [24:0] src_r, dst_r;
   logic [15:0] data_r, fill_data_r;
   logic        fill_r, virt_r, pend_r;
   logic        step, abort_now;

   // Address bit 0 is forced to zero at latch time, so the raw bits are dropped.
   logic unused_bits;
   assign unused_bits = src_addr[0] ^ dst_addr[0];

   assign abort_now = pend_r | abort;

   // Next-state decode; step marks the folded NEXT on the final WWAIT cycle.
   always_comb begin
      next_state = state;
      step       = 1'b0;
      case (state)
         IDLE:  if (start) next_state = SETUP;
         SETUP: begin
            if (cnt == 16'd0) next_state = DONE;
            else              next_state = fill_r ? WRITE : READ;
         end
         READ:  if (timer == S_LAST) next_state = RWAIT;
         RWAIT: if (timer == W_LAST) next_state = WRITE;
         WRITE: if (timer == S_LAST) next_state = WWAIT;
         WWAIT: begin
            if (timer == W_LAST) begin
               step = 1'b1;
               if (cnt == 16'd1 || abort_now) next_state = DONE;
               else                           next_state = fill_r ? WRITE : READ;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register and per-window timer, restarted on every state change.
   always_ff @(posedge clk_sys or negedge init_n) begin
      if (!init_n) begin
         state <= IDLE;
         timer <= 16'd0;
      end else begin
         state <= next_state;
         if (next_state != state) timer <= 16'd0;
         else                     timer <= timer + 16'd1;
      end
   end

   // Operation registers: latch at start, advance pointers and count per word.
   always_ff @(posedge clk_sys or negedge init_n) begin
      if (!init_n) begin
         src_r       <= 25'd0;
         dst_r       <= 25'd0;
         cnt         <= 16'd0;
         fill_r      <= 1'b0;
         fill_data_r <= 16'd0;
         virt_r      <= 1'b0;
         data_r      <= 16'd0;
      end else begin
         if (state == IDLE && start) begin
            src_r       <= {src_addr[24:1], 1'b0};
            dst_r       <= {dst_addr[24:1], 1'b0};
            cnt         <= len;
            fill_r      <= fill;
            fill_data_r <= fill_data;
            virt_r      <= virt;
         end
         if (state == RWAIT && timer == W_LAST) data_r <= bus.mem_copy_data_o;
         if (step) begin
            cnt   <= cnt - 16'd1;
            src_r <= src_r + 25'd2;
            dst_r <= dst_r + 25'd2;
         end
      end
   end

   // Sticky abort request and the early-termination status it produces.
   always_ff @(posedge clk_sys or negedge init_n) begin
      if (!init_n) begin
         pend_r  <= 1'b0;
         aborted <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            pend_r  <= 1'b0;
            aborted <= 1'b0;
         end
      end else begin
         if (abort) pend_r <= 1'b1;
         if (step && abort_now) aborted <= 1'b1;
      end
   end

   // Bus outputs derive from state and latched registers, so they hold
   // steady across each strobe and wait window and read zero in reset.
   assign busy                = (state != IDLE);
   assign done                = (state == DONE);
   assign bus.mem_copy        = busy;
   assign bus.mem_copy_virt   = busy & virt_r;
   assign bus.mem_copy_rd     = (state == READ);
   assign bus.mem_copy_we     = (state == WRITE);
   assign bus.mem_copy_addr   = (state == READ  || state == RWAIT) ? src_r :
                                (state == WRITE || state == WWAIT) ? dst_r : 25'd0;
   assign bus.mem_copy_data_i = (state == WRITE || state == WWAIT) ?
                                (fill_r ? fill_data_r : data_r) : 16'd0;

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter STROBE, default 4, meaning the number of clk_sys cycles mem_copy_rd or mem_copy_we is held high per access (minimum 1).
REQ-002 SHALL have parameter WAIT, default 24, meaning the number of clk_sys cycles the strobe is held low after each access before the next step (minimum 1).
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port init_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-006 SHALL have port fill, input, 1 bit: 1 selects fill (write fill_data only), 0 selects copy.
REQ-007 SHALL have port virt, input, 1 bit: latched at start and driven on mem_copy_virt.
REQ-008 SHALL have ports src_addr and dst_addr, inputs, 25 bits each: byte addresses; bit 0 is ignored and treated as 0.
REQ-009 SHALL have port len, input, 16 bits: word count, 0..65535.
REQ-010 SHALL have port fill_data, input, 16 bits: write data used in fill mode.
REQ-011 SHALL have port abort, input, 1 bit: request early termination.
REQ-012 SHALL have port mem_copy, output, 1 bit: bus ownership towards the SDRAM wishbone bridge.
REQ-013 SHALL have port mem_copy_virt, output, 1 bit: virtual/physical address select.
REQ-014 SHALL have port mem_copy_addr, output, 25 bits: byte address of the current access.
REQ-015 SHALL have port mem_copy_data_i, output, 16 bits: write data.
REQ-016 SHALL have port mem_copy_data_o, input, 16 bits: read data returned by the controller.
REQ-017 SHALL have ports mem_copy_rd and mem_copy_we, outputs, 1 bit each: read and write strobes.
REQ-018 SHALL have ports busy, done and aborted, outputs, 1 bit each: operation active; one-cycle completion pulse; termination was early.

Function
REQ-019 SHALL implement the states IDLE, SETUP, READ, RWAIT, WRITE, WWAIT, NEXT and DONE.
REQ-020 When start=1 in IDLE, SHALL on the next edge:
- latch src_addr, dst_addr, len, fill, fill_data and virt;
- clear aborted;
- set busy=1 and mem_copy=1;
- enter SETUP.
REQ-021 SETUP SHALL last 1 cycle with both strobes low, then:
- go to DONE if the remaining count is 0;
- otherwise go to WRITE in fill mode, or READ in copy mode.
REQ-022 In READ, SHALL drive mem_copy_addr=src and mem_copy_rd=1 for STROBE cycles, then go to RWAIT.
REQ-023 In RWAIT, SHALL hold mem_copy_rd=0 for WAIT cycles, latch mem_copy_data_o into the data register in the last RWAIT cycle, then go to WRITE.
REQ-024 In WRITE, SHALL drive mem_copy_addr=dst, mem_copy_data_i=data register (or fill_data in fill mode), and mem_copy_we=1 for STROBE cycles, then go to WWAIT.
REQ-025 In WWAIT, SHALL hold mem_copy_we=0 for WAIT cycles, then go to NEXT.
REQ-026 mem_copy_addr and mem_copy_data_i SHALL stay stable throughout every strobe window and its following wait window.
REQ-027 NEXT SHALL be 0 cycles (folded into the last WWAIT cycle):
- decrement the count;
- add 2 to src and dst, modulo 2^25 (wrap 0x1FFFFFE -> 0x0000000);
- go to DONE when the count reaches 0 or an abort is pending, otherwise to READ or WRITE.
REQ-028 Per-word latency SHALL be 2*(STROBE+WAIT) cycles in copy mode and STROBE+WAIT cycles in fill mode; with start sampled in cycle 0, done SHALL be high in cycle 2 + len*per-word.
REQ-029 In DONE, SHALL pulse done=1 for exactly 1 cycle, drop busy and mem_copy in the same cycle, and return to IDLE.
REQ-030 mem_copy_rd and mem_copy_we SHALL never both be high; both SHALL be low whenever mem_copy=0.
REQ-031 abort=1 in any busy cycle SHALL set a sticky pending flag; the current word SHALL complete; DONE then follows with aborted=1.
REQ-032 abort in IDLE SHALL be ignored.
REQ-033 start while busy SHALL be ignored.
REQ-034 Copies SHALL always run ascending; overlapping regions are not corrected.

Reset
REQ-035 init_n=0 SHALL asynchronously force state IDLE and clear all registers.
REQ-036 During reset, all outputs SHALL be 0, including mem_copy_addr and mem_copy_data_i.
REQ-037 Reset mid-operation SHALL abandon the transfer with no done pulse; the first start after release begins a fresh operation.

Verification
REQ-038 Copy: src=0x00100, dst=0x04000, len=2, defaults -> reads at 0x00100 and 0x00102, writes to 0x04000 and 0x04002 carry the read data; done high in cycle 114.
REQ-039 Fill: dst=0x14000, len=3, fill_data=0xA5A5 -> three write strobes at 0x14000, 0x14002 and 0x14004 with data 0xA5A5, no read strobe; done in cycle 86.
REQ-040 len=0 -> no strobe issued; busy high for cycles 1-2; done in cycle 2.
REQ-041 Wrap: dst=0x1FFFFFE, len=2 fill -> write addresses are 0x1FFFFFE then 0x0000000.
REQ-042 Abort asserted in cycle 10 of a len=5 copy -> exactly one word copied; done in cycle 58 with aborted=1.
REQ-043 init_n pulsed low in cycle 40 of a copy -> all outputs 0 immediately with no done pulse; a new start then runs normally.
